// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: memory access size codes, the MEM
// stage FSM state encoding and an alignment helper.
package core_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } mem_state_e;

  // Size code 3 is reserved and behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      MEM_SIZE_BYTE: mis = 1'b0;
      MEM_SIZE_HALF: mis = lo[0];
      default:       mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/core_mem_align.sv
// Byte-lane steering for the MEM stage: store mask/data replication and
// load lane select with sign or zero extension. Purely combinational.
module core_mem_align
  import core_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] st_din,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wmask = 4'b1111;
    st_din   = st_wdata;
    case (st_size)
      MEM_SIZE_BYTE: begin
        st_wmask = 4'b0001 << st_lo;
        st_din   = {4{st_wdata[7:0]}};
      end
      MEM_SIZE_HALF: begin
        st_wmask = 4'b0011 << {st_lo[1], 1'b0};
        st_din   = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shift = ld_word >> {ld_lo, 3'b000};
    ld_byte  = ld_shift[7:0];
    ld_half  = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data  = ld_word;
    case (ld_size)
      MEM_SIZE_BYTE: ld_data = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
      MEM_SIZE_HALF: ld_data = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/core_pipe_mem.sv
// MEM stage of the RV32 pipeline: one data-RAM transaction per accepted
// instruction. Optional MEM_MISALIGN_TRAP_EN adds the mem_misalign output.
module core_pipe_mem
  import core_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_validout,
  output logic        mem_allowin,
  output logic        mem_validout,
  input  logic        wb_allowin,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_unsigned,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_wdata,
  input  logic [31:0] ex_result_pc,
  input  logic [31:0] ex_result_link_addr,
  input  logic [31:0] ex_result_value,
  input  logic        ex_result_jmp,
  input  logic        ex_result_link,
  input  logic        ex_result_computed,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_wmask,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic [4:0]  mem_rd,
  output logic [4:0]  mem_rs1,
  output logic [4:0]  mem_rs2,
  output logic        mem_write_rd,
  output logic [31:0] ram_dout,
  output logic [31:0] mem_result_pc,
  output logic [31:0] mem_result_link_addr,
  output logic [31:0] mem_result_value,
  output logic        mem_result_jmp,
  output logic        mem_result_link,
  output logic        mem_result_computed,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        mem_misalign,
`endif
  output logic        mem_bus_err
);

  localparam logic [31:0] TO_LAST = 32'(ACK_TIMEOUT - 1);

  mem_state_e  state, state_nxt;
  logic        accept, mem_op, is_store, misalign_now, ack_done, timeout;
  logic [31:0] to_cnt;
  logic        ld_q, uns_q;
  logic [1:0]  size_q, lo_q;
  logic [3:0]  st_wmask;
  logic [31:0] st_din, ld_data;

  // Handshakes: a transfer happens on a rising edge where the producer's valid
  // and the consumer's allowin are both high; the producer holds its payload
  // until then. MEM holds one instruction, so allowin is high only in IDLE.
  assign mem_allowin  = (state == IDLE);
  assign mem_validout = (state == HOLD);
  assign accept       = ex_validout & mem_allowin;
  assign mem_op       = ex_mem_read | ex_mem_write;
  assign is_store     = ex_mem_write & ~ex_mem_read;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_now = mem_op & is_misaligned(ex_mem_size, ex_mem_addr[1:0]);
`else
  assign misalign_now = 1'b0;
`endif
  assign ack_done = (state == ACCESS) & ram_ack;
  assign timeout  = (ACK_TIMEOUT != 0) && (state == ACCESS) && !ram_ack && (to_cnt == TO_LAST);

  core_mem_align u_align (
    .st_size     (ex_mem_size),
    .st_lo       (ex_mem_addr[1:0]),
    .st_wdata    (ex_mem_wdata),
    .st_wmask    (st_wmask),
    .st_din      (st_din),
    .ld_size     (size_q),
    .ld_lo       (lo_q),
    .ld_unsigned (uns_q),
    .ld_word     (ram_rdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept) state_nxt = (mem_op && !misalign_now) ? ACCESS : HOLD;
      ACCESS: if (ack_done || timeout) state_nxt = HOLD;
      HOLD:   if (wb_allowin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt               <= '0;
      ram_req              <= 1'b0;
      ram_we               <= 1'b0;
      ram_addr             <= '0;
      ram_wmask            <= '0;
      ram_din              <= '0;
      ram_dout             <= '0;
      ld_q                 <= 1'b0;
      uns_q                <= 1'b0;
      size_q               <= '0;
      lo_q                 <= '0;
      mem_rd               <= '0;
      mem_rs1              <= '0;
      mem_rs2              <= '0;
      mem_write_rd         <= 1'b0;
      mem_result_pc        <= '0;
      mem_result_link_addr <= '0;
      mem_result_value     <= '0;
      mem_result_jmp       <= 1'b0;
      mem_result_link      <= 1'b0;
      mem_result_computed  <= 1'b0;
      mem_bus_err          <= 1'b0;
    end else begin
      if ((state == ACCESS) && !ram_ack && !timeout) to_cnt <= to_cnt + 32'd1;
      else                                           to_cnt <= '0;

      if (accept) begin
        ram_req              <= mem_op & ~misalign_now;
        ram_we               <= is_store & ~misalign_now;
        ram_addr             <= {ex_mem_addr[31:2], 2'b00};
        ram_wmask            <= (is_store && !misalign_now) ? st_wmask : 4'b0000;
        ram_din              <= st_din;
        ram_dout             <= '0;
        ld_q                 <= ex_mem_read;
        uns_q                <= ex_mem_unsigned;
        size_q               <= ex_mem_size;
        lo_q                 <= ex_mem_addr[1:0];
        mem_rd               <= ex_rd;
        mem_rs1              <= ex_rs1;
        mem_rs2              <= ex_rs2;
        mem_write_rd         <= ex_mem_read & ~misalign_now;
        mem_result_pc        <= ex_result_pc;
        mem_result_link_addr <= ex_result_link_addr;
        mem_result_value     <= ex_result_value;
        mem_result_jmp       <= ex_result_jmp;
        mem_result_link      <= ex_result_link;
        mem_result_computed  <= ex_result_computed;
        mem_bus_err          <= 1'b0;
      end else if (ack_done) begin
        ram_req <= 1'b0;
        if (ld_q) ram_dout <= ld_data;
      end else if (timeout) begin
        ram_req      <= 1'b0;
        ram_dout     <= '0;
        mem_write_rd <= 1'b0;
        mem_bus_err  <= 1'b1;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mem_misalign <= 1'b0;
    else if (accept) mem_misalign <= misalign_now;
  end
`endif

endmodule

// File: tb/tb_core_pipe_mem.sv
// Self-checking bench for core_pipe_mem (ACK_TIMEOUT=4): directed cases then
// random transactions against a byte-level reference model.
module tb_core_pipe_mem;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_validout, mem_allowin, mem_validout, wb_allowin;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_mem_read, ex_mem_write, ex_mem_unsigned;
  logic [1:0]  ex_mem_size;
  logic [31:0] ex_mem_addr, ex_mem_wdata;
  logic [31:0] ex_result_pc, ex_result_link_addr, ex_result_value;
  logic        ex_result_jmp, ex_result_link, ex_result_computed;
  logic        ram_req, ram_we, ram_ack;
  logic [31:0] ram_addr, ram_din, ram_rdata, ram_dout;
  logic [3:0]  ram_wmask;
  logic [4:0]  mem_rd, mem_rs1, mem_rs2;
  logic        mem_write_rd, mem_bus_err;
  logic [31:0] mem_result_pc, mem_result_link_addr, mem_result_value;
  logic        mem_result_jmp, mem_result_link, mem_result_computed;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misalign;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  core_pipe_mem #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_validout(ex_validout), .mem_allowin(mem_allowin),
    .mem_validout(mem_validout), .wb_allowin(wb_allowin),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
    .ex_result_pc(ex_result_pc), .ex_result_link_addr(ex_result_link_addr),
    .ex_result_value(ex_result_value), .ex_result_jmp(ex_result_jmp),
    .ex_result_link(ex_result_link), .ex_result_computed(ex_result_computed),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wmask(ram_wmask), .ram_din(ram_din), .ram_rdata(ram_rdata),
    .ram_ack(ram_ack),
    .mem_rd(mem_rd), .mem_rs1(mem_rs1), .mem_rs2(mem_rs2),
    .mem_write_rd(mem_write_rd), .ram_dout(ram_dout),
    .mem_result_pc(mem_result_pc), .mem_result_link_addr(mem_result_link_addr),
    .mem_result_value(mem_result_value), .mem_result_jmp(mem_result_jmp),
    .mem_result_link(mem_result_link), .mem_result_computed(mem_result_computed),
`ifdef MEM_MISALIGN_TRAP_EN
    .mem_misalign(mem_misalign),
`endif
    .mem_bus_err(mem_bus_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: access width in bytes, offset truncated to that width
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic int eff_off(input logic [1:0] size, input logic [31:0] addr);
    return int'(addr % 4) & ~(nbytes(size) - 1);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns,
                                             input logic [31:0] addr, input logic [31:0] word);
    int nb;
    logic [63:0] lmask, v;
    nb    = nbytes(size);
    lmask = (64'd1 << (8 * nb)) - 64'd1;
    v     = (64'(word) >> (8 * eff_off(size, addr))) & lmask;
    if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~lmask;
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_wmask(input logic [1:0] size, input logic [31:0] addr);
    int m;
    m = ((1 << nbytes(size)) - 1) << eff_off(size, addr);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_din(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = wdata[8*(i % nbytes(size)) +: 8];
    return d;
  endfunction

  function automatic bit model_trap(input bit is_mem, input logic [1:0] size, input logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
    return is_mem && (int'(addr % 4) % nbytes(size) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // driver: one full instruction through MEM. wait_n<0 means the RAM never acks.
  task automatic do_txn(input bit rd_f, input bit wr_f, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [31:0] value,
                        input int wait_n, input int stall);
    bit is_mem, is_ld, is_st, trap, tmo;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, link;
    logic [2:0]  flags;
    logic [31:0] exp_dout, hold_dout;
    int k;
    is_mem = rd_f | wr_f;
    is_ld  = rd_f;
    is_st  = wr_f & ~rd_f;
    trap   = model_trap(is_mem, size, addr);
    tmo    = is_mem && !trap && wait_n < 0;
    exp_q.push_back((is_ld && !trap && !tmo) ? model_load(size, uns, addr, rdata) : 32'h0);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    pc = $urandom; link = $urandom; flags = 3'($urandom);

    check("allowin_idle", {31'b0, mem_allowin}, 32'd1);
    ex_validout = 1'b1;
    ex_rd = rd; ex_rs1 = rs1; ex_rs2 = rs2;
    ex_mem_read = rd_f; ex_mem_write = wr_f; ex_mem_size = size; ex_mem_unsigned = uns;
    ex_mem_addr = addr; ex_mem_wdata = wdata;
    ex_result_pc = pc; ex_result_link_addr = link; ex_result_value = value;
    {ex_result_jmp, ex_result_link, ex_result_computed} = flags;
    @(posedge clk); #1;
    ex_validout = 1'b0;
    ex_rd = 5'($urandom); ex_mem_addr = $urandom; ex_mem_wdata = $urandom; ex_result_value = $urandom;

    if (is_mem && !trap) begin
      k = 0;
      check("ram_we", {31'b0, ram_we}, {31'b0, is_st});
      if (is_st) begin
        check("ram_wmask", {28'b0, ram_wmask}, {28'b0, model_wmask(size, addr)});
        check("ram_din", ram_din, model_din(size, wdata));
      end
      while (ram_req === 1'b1 && k < 20) begin
        check("ram_addr", ram_addr, addr & 32'hFFFF_FFFC);
        check("validout_in_access", {31'b0, mem_validout}, 32'd0);
        ram_ack   = (k == wait_n);
        ram_rdata = ram_ack ? rdata : $urandom;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        k++;
      end
      check("access_cycles", 32'(k), tmo ? 32'(TO) : 32'(wait_n + 1));
    end

    exp_dout = exp_q.pop_front();
    check("ram_req_low", {31'b0, ram_req}, 32'd0);
    check("validout", {31'b0, mem_validout}, 32'd1);
    check("mem_rd", {27'b0, mem_rd}, {27'b0, rd});
    check("mem_rs", {22'b0, mem_rs1, mem_rs2}, {22'b0, rs1, rs2});
    check("write_rd", {31'b0, mem_write_rd}, {31'b0, is_ld && !trap && !tmo});
    check("ram_dout", ram_dout, exp_dout);
    check("bus_err", {31'b0, mem_bus_err}, {31'b0, tmo});
    check("result_value", mem_result_value, value);
    check("result_pc_link", mem_result_pc ^ mem_result_link_addr, pc ^ link);
    check("result_flags", {29'b0, mem_result_jmp, mem_result_link, mem_result_computed}, {29'b0, flags});
`ifdef MEM_MISALIGN_TRAP_EN
    check("misalign", {31'b0, mem_misalign}, {31'b0, trap});
`endif

    hold_dout = exp_dout;
    wb_allowin = 1'b0;
    for (int s = 0; s < stall; s++) begin
      ex_validout = 1'b1;
      ex_rd = 5'($urandom);
      @(posedge clk); #1;
      check("stall_validout", {31'b0, mem_validout}, 32'd1);
      check("stall_allowin", {31'b0, mem_allowin}, 32'd0);
      check("stall_rd", {27'b0, mem_rd}, {27'b0, rd});
      check("stall_dout", ram_dout, hold_dout);
    end
    ex_validout = 1'b0;
    wb_allowin = 1'b1;
    @(posedge clk); #1;
    check("release_validout", {31'b0, mem_validout}, 32'd0);
    check("release_allowin", {31'b0, mem_allowin}, 32'd1);
  endtask

  initial begin
    bit rf, wf;
    int kind, w;
    rst_n = 1'b0; ex_validout = 1'b0; wb_allowin = 1'b1; ram_ack = 1'b0; ram_rdata = '0;
    ex_rd = '0; ex_rs1 = '0; ex_rs2 = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_mem_size = '0; ex_mem_unsigned = 1'b0; ex_mem_addr = '0; ex_mem_wdata = '0;
    ex_result_pc = '0; ex_result_link_addr = '0; ex_result_value = '0;
    ex_result_jmp = 1'b0; ex_result_link = 1'b0; ex_result_computed = 1'b0;
    repeat (2) @(posedge clk); #1;

    check("rst_allowin", {31'b0, mem_allowin}, 32'd1);
    check("rst_validout", {31'b0, mem_validout}, 32'd0);
    check("rst_ram_req", {31'b0, ram_req}, 32'd0);
    check("rst_wmask", {28'b0, ram_wmask}, 32'd0);
    check("rst_dout", ram_dout, 32'd0);
    check("rst_bus_err", {31'b0, mem_bus_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    do_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 32'h1234, 0, 0);
    do_txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF_FF00, 32'h1, 2, 0);
    do_txn(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF_FF00, 32'h2, 2, 0);
    do_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h202, 32'hAAAA_BEEF, 32'h0, 32'h3, 0, 5);
    do_txn(1'b1, 1'b1, 2'd1, 1'b0, 32'h306, 32'h5555_5555, 32'h8001_7FFF, 32'h4, 0, 1);
    do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'hDEAD_BEEF, 32'h5, -1, 2);
    do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h404, 32'h0, 32'hCAFE_F00D, 32'h6, 3, 0);
    do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h1234_5678, 32'h7, 0, 0);

    // reset in the middle of an access, then a stray ack
    ex_validout = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_mem_size = 2'd2; ex_mem_addr = 32'h500;
    @(posedge clk); #1;
    ex_validout = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("mid_access_req", {31'b0, ram_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'b0, ram_req}, 32'd0);
    check("async_rst_allowin", {31'b0, mem_allowin}, 32'd1);
    ram_ack = 1'b1; ram_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ram_ack = 1'b0;
    check("late_ack_validout", {31'b0, mem_validout}, 32'd0);
    check("late_ack_req", {31'b0, ram_req}, 32'd0);
    check("late_ack_allowin", {31'b0, mem_allowin}, 32'd1);

    // random transactions
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      rf = (kind == 1) || (kind == 3);
      wf = (kind == 2) || (kind == 3);
      w = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
      do_txn(rf, wf, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
             $urandom, $urandom, w, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
